// File: rtl/clk_en_mux.sv
// clk_en_mux: per-channel clock-enable strobes plus a glitch-free, period-aligned channel select.
// Optional feature macro: CLK_EN_MUX_PHASE_RESET_EN zeroes the new channel's counter on a switch.
module clk_en_mux #(
  parameter int NCH   = 4,
  parameter int DIV_W = 8,
  parameter int SEL_W = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 RESET,
  input  logic [NCH*DIV_W-1:0] div_cfg,
  input  logic [SEL_W-1:0]     sel,
  output logic [NCH-1:0]       ce_all,
  output logic                 ce_out,
  output logic                 div_out,
  output logic [SEL_W-1:0]     cur_sel,
  output logic                 busy
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [SEL_W:0] NCH_L = (SEL_W+1)'(NCH);

  state_t state;
  state_t state_nxt;
  logic   sel_ok;
  logic   ce_cur;
  logic   do_switch;

  assign sel_ok = ({1'b0, sel} < NCH_L);
  assign ce_cur = ce_all[cur_sel];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DIV_W-1:0] div_i;
    logic [DIV_W-1:0] last_i;
    logic [DIV_W-1:0] cnt;
    logic             zero_i;

    assign div_i  = div_cfg[i*DIV_W +: DIV_W];
    // Ratios 0 and 1 both mean "every cycle"; >= also catches a ratio lowered mid-period.
    assign last_i = (div_i == '0) ? '0 : div_i - DIV_W'(1);
    assign ce_all[i] = (cnt >= last_i);

`ifdef CLK_EN_MUX_PHASE_RESET_EN
    assign zero_i = do_switch && (sel == SEL_W'(i));
`else
    assign zero_i = 1'b0;
`endif

    // NOTE: counters are real state whose phase is visible at the outputs, so they are reset, not left to power-up values.
    always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
        cnt <= '0;
      end else if (ce_all[i] || zero_i) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
  always_comb begin
    state_nxt = state;
    do_switch = 1'b0;
    unique case (state)
      RUN: begin
        if (sel_ok && (sel != cur_sel)) begin
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (!sel_ok || (sel == cur_sel)) begin
          state_nxt = RUN;
        end else if (ce_cur) begin
          // Old channel's final strobe is also registered into ce_out at this edge.
          state_nxt = RUN;
          do_switch = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    busy = (state == PEND);
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      cur_sel <= '0;
      ce_out  <= 1'b0;
      div_out <= 1'b0;
    end else begin
      ce_out  <= ce_cur;
      div_out <= div_out ^ ce_cur;
      if (do_switch) begin
        cur_sel <= sel;
      end
    end
  end

endmodule

// File: tb/tb_clk_en_mux.sv
// Self-checking bench for clk_en_mux: directed scenarios then random select/ratio traffic,
// compared each cycle against a cycle-count based reference model.
module tb_clk_en_mux;

  localparam int NCH   = 4;
  localparam int DIV_W = 8;
  localparam int SEL_W = $clog2(NCH);

  logic                 clk = 1'b0;
  logic                 RESET;
  logic [NCH*DIV_W-1:0] div_cfg;
  logic [SEL_W-1:0]     sel;
  logic [NCH-1:0]       ce_all;
  logic                 ce_out;
  logic                 div_out;
  logic [SEL_W-1:0]     cur_sel;
  logic                 busy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: each channel remembers the tick at which it last restarted.
  int now;
  int base [NCH];
  int m_cur;
  bit m_pend;
  bit m_ce_out;
  bit m_div_out;

  always #5 clk = ~clk;

  clk_en_mux #(.NCH(NCH), .DIV_W(DIV_W), .SEL_W(SEL_W)) dut (
    .clk     (clk),
    .RESET   (RESET),
    .div_cfg (div_cfg),
    .sel     (sel),
    .ce_all  (ce_all),
    .ce_out  (ce_out),
    .div_out (div_out),
    .cur_sel (cur_sel),
    .busy    (busy)
  );

  function automatic int ratio(input int i);
    int v;
    v = int'(div_cfg[i*DIV_W +: DIV_W]);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic bit m_ce(input int i);
    return (now - base[i]) >= (ratio(i) - 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    now = 0;
    for (int i = 0; i < NCH; i++) base[i] = 0;
    m_cur     = 0;
    m_pend    = 1'b0;
    m_ce_out  = 1'b0;
    m_div_out = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [NCH-1:0] e;
    for (int i = 0; i < NCH; i++) e[i] = m_ce(i);
    check($sformatf("%s.ce_all", tag), 32'(ce_all), 32'(e));
    check($sformatf("%s.ce_out", tag), 32'(ce_out), 32'(m_ce_out));
    check($sformatf("%s.div_out", tag), 32'(div_out), 32'(m_div_out));
    check($sformatf("%s.cur_sel", tag), 32'(cur_sel), 32'(m_cur));
    check($sformatf("%s.busy", tag), 32'(busy), 32'(m_pend));
  endtask

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_next();
    bit st [NCH];
    bit in_range;
    bit sw;
    int s;
    s = int'(sel);
    for (int i = 0; i < NCH; i++) st[i] = m_ce(i);
    in_range  = (s < NCH);
    sw        = m_pend && in_range && (s != m_cur) && st[m_cur];
    m_ce_out  = st[m_cur];
    m_div_out = m_div_out ^ st[m_cur];
    if (!m_pend) m_pend = in_range && (s != m_cur);
    else         m_pend = in_range && (s != m_cur) && !st[m_cur];
    now++;
    for (int i = 0; i < NCH; i++) if (st[i]) base[i] = now;
`ifdef CLK_EN_MUX_PHASE_RESET_EN
    if (sw) base[s] = now;
`endif
    if (sw) m_cur = s;
  endtask

  task automatic step(input string tag);
    #1;
    check_all(tag);
    model_next();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n, input string tag);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  task automatic set_div(input int ch, input int v);
    div_cfg[ch*DIV_W +: DIV_W] = DIV_W'(v);
  endtask

  initial begin
    int guard;

    // Reset and steady cadence: ratios {5,4,3,2}, channel 0 selected.
    RESET   = 1'b1;
    sel     = '0;
    div_cfg = {8'd5, 8'd4, 8'd3, 8'd2};
    model_reset();
    @(negedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    RESET = 1'b0;
    run(21, "steady");

    // Switch 0 -> 2 mid-period.
    sel = SEL_W'(2);
    run(12, "sw02");

    // Back to 0, then a select bounced 0 -> 1 -> 0 inside the pending window.
    sel = '0;
    run(10, "sw20");
    sel = SEL_W'(1);
    step("bounce1");
    sel = '0;
    run(10, "bounce0");

    // Ratio 0 and 1 on channel 1 give a continuous enable; then 200 from cnt=0.
    set_div(1, 0);
    sel = SEL_W'(1);
    run(10, "div0");
    set_div(1, 1);
    run(5, "div1");
    set_div(1, 200);
    run(205, "div200");

    // Lower channel 2 from 9 to 3 while its count sits at 6.
    set_div(2, 9);
    guard = 0;
    while (((now - base[2]) != 6) && (guard < 20)) begin
      step("wait6");
      guard++;
    end
    check("cnt2_reached_6", 32'(now - base[2]), 32'd6);
    set_div(2, 3);
    run(10, "lower");

    // Asynchronous reset while a switch is pending.
    sel = '0;
    step("pre_rst");
    #1;
    check_all("pend");
    check("pend.busy_set", 32'(busy), 32'd1);
    RESET = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    div_cfg = {8'd5, 8'd4, 8'd3, 8'd2};
    sel     = '0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_all("rst_hold");
    @(negedge clk);
    RESET = 1'b0;
    run(21, "post_rst");

    // Random select and ratio traffic.
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 7) == 0) sel = SEL_W'($urandom_range(0, NCH - 1));
      if ($urandom_range(0, 15) == 0) set_div(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 12)));
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
